// File: rtl/sparc_mul_arb_pkg.sv
// rtl/sparc_mul_arb_pkg.sv - shared types and defaults for the multiplier issue arbiter
package sparc_mul_arb_pkg;

   localparam logic SRC_EXU = 1'b0;
   localparam logic SRC_SPU = 1'b1;

   localparam int DEF_MUL_LAT    = 5;
   localparam int DEF_STARVE_MAX = 3;

   typedef struct packed {
      logic vld;
      logic src;
      logic acc;
   } tag_t;

   localparam tag_t TAG_NONE = '0;

endpackage

// File: rtl/sparc_mul_arb_if.sv
// rtl/sparc_mul_arb_if.sv - request/grant/issue/ack bundle between requesters and the arbiter
interface sparc_mul_arb_if;

   logic exu_mul_req;
   logic spu_mul_req;
   logic spu_mul_acc;
   logic spu_shf_req;
   logic exu_gnt;
   logic spu_gnt;
   logic spu_shf_gnt;
   logic issue_vld;
   logic issue_spick;
   logic issue_acc;
   logic issue_shf;
   logic mul_exu_ack;
   logic mul_spu_ack;
   logic mul_spu_shf_ack;
   logic busy;

   modport slave (
      input  exu_mul_req, spu_mul_req, spu_mul_acc, spu_shf_req,
      output exu_gnt, spu_gnt, spu_shf_gnt,
      output issue_vld, issue_spick, issue_acc, issue_shf,
      output mul_exu_ack, mul_spu_ack, mul_spu_shf_ack, busy
   );

   modport master (
      output exu_mul_req, spu_mul_req, spu_mul_acc, spu_shf_req,
      input  exu_gnt, spu_gnt, spu_shf_gnt,
      input  issue_vld, issue_spick, issue_acc, issue_shf,
      input  mul_exu_ack, mul_spu_ack, mul_spu_shf_ack, busy
   );

endinterface

// File: rtl/sparc_mul_arb_pipe.sv
// rtl/sparc_mul_arb_pipe.sv - in-flight tag shift register tracking issued multiplies
module sparc_mul_arb_pipe
   import sparc_mul_arb_pkg::*;
#(
   parameter int MUL_LAT = DEF_MUL_LAT
) (
   input  logic rclk,
   input  logic rst,
   input  tag_t tag_in,
   output tag_t tag_last,
   output logic acc_inflight,
   output logic any_vld
);

   tag_t [MUL_LAT-1:0] stage;

   always_ff @(posedge rclk) begin
      if (rst) begin
         stage <= '0;
      end else begin
         stage <= {stage[MUL_LAT-2:0], tag_in};
      end
   end

   // The last stage is the write-back cycle: ACCUM is already final there,
   // so only earlier stages count as an accumulator hazard.
   always_comb begin
      acc_inflight = 1'b0;
      any_vld      = 1'b0;
      for (int i = 0; i < MUL_LAT - 1; i++) begin
         acc_inflight = acc_inflight | (stage[i].vld & stage[i].acc);
      end
      for (int i = 0; i < MUL_LAT; i++) begin
         any_vld = any_vld | stage[i].vld;
      end
   end

   assign tag_last = stage[MUL_LAT-1];

endmodule

// File: rtl/sparc_mul_arb.sv
// rtl/sparc_mul_arb.sv - EXU/SPU issue arbiter with starvation guard and accumulator hazards
module sparc_mul_arb
   import sparc_mul_arb_pkg::*;
#(
   parameter int MUL_LAT    = DEF_MUL_LAT,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic            rclk,
   input  logic            rst,
   sparc_mul_arb_if.slave  bus
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_cnt;
   logic       spu_prio;
   logic       shf_pend;
   logic       acc_inflight;
   logic       pipe_vld;
   logic       spu_elig;
   logic       contended;
   logic       spu_win;
   logic       exu_win;
   logic       shf_win;
   tag_t       tag_in;
   tag_t       tag_last;

   always_comb begin
      spu_elig  = bus.spu_mul_req & (bus.spu_mul_acc | ~acc_inflight);
      contended = bus.exu_mul_req & spu_elig;
      spu_win   = spu_elig & (~bus.exu_mul_req | spu_prio) & ~rst;
      exu_win   = bus.exu_mul_req & ~spu_win & ~rst;
      // A pending SPU multiply goes first; the shift waits behind it.
      shf_win   = bus.spu_shf_req & ~bus.spu_mul_req & ~bus.exu_mul_req
                & ~acc_inflight & ~rst;
      tag_in     = TAG_NONE;
      tag_in.vld = exu_win | spu_win;
      tag_in.src = spu_win ? SRC_SPU : SRC_EXU;
      tag_in.acc = spu_win & bus.spu_mul_acc;
   end

   always_ff @(posedge rclk) begin
      if (rst) begin
         starve_cnt <= '0;
         spu_prio   <= 1'b0;
         shf_pend   <= 1'b0;
      end else begin
         shf_pend <= shf_win;
         if (spu_win) begin
            starve_cnt <= '0;
            spu_prio   <= 1'b0;
         end else if (exu_win && contended) begin
            starve_cnt <= starve_cnt + 4'd1;
            if (starve_cnt + 4'd1 == STARVE_LIM) begin
               spu_prio <= 1'b1;
            end
         end
      end
   end

   sparc_mul_arb_pipe #(
      .MUL_LAT (MUL_LAT)
   ) u_pipe (
      .rclk         (rclk),
      .rst          (rst),
      .tag_in       (tag_in),
      .tag_last     (tag_last),
      .acc_inflight (acc_inflight),
      .any_vld      (pipe_vld)
   );

   assign bus.exu_gnt     = exu_win;
   assign bus.spu_gnt     = spu_win;
   assign bus.spu_shf_gnt = shf_win;
   assign bus.issue_vld   = exu_win | spu_win;
   assign bus.issue_spick = spu_win;
   assign bus.issue_acc   = spu_win & bus.spu_mul_acc;
   assign bus.issue_shf   = shf_win;

   // Only SPU ops ever carry acc, so acc alone also identifies an SPU result.
   assign bus.mul_exu_ack     = ~rst & tag_last.vld & (tag_last.src == SRC_EXU) & ~tag_last.acc;
   assign bus.mul_spu_ack     = ~rst & tag_last.vld & ((tag_last.src == SRC_SPU) | tag_last.acc);
   assign bus.mul_spu_shf_ack = ~rst & shf_pend;
   assign bus.busy            = ~rst & (pipe_vld | shf_pend);

endmodule

// File: tb/tb_sparc_mul_arb.sv
// tb/tb_sparc_mul_arb.sv - table-driven bench with ack scoreboard for sparc_mul_arb
module tb_sparc_mul_arb;
   import sparc_mul_arb_pkg::*;

   localparam int LAT = 5;

   typedef struct {
      logic exu, spu, acc, shf, rst;
      logic eg, sg, shg;
   } vec_t;

   typedef struct {
      int due;
      int kind;
   } ev_t;

   logic rclk;
   logic rst;
   vec_t vecs[$];
   ev_t  sb[$];
   ev_t  keep[$];
   int   n_vec;
   int   n_cmp;
   int   n_err;

   sparc_mul_arb_if bus();

   sparc_mul_arb #(
      .MUL_LAT    (LAT),
      .STARVE_MAX (3)
   ) dut (
      .rclk (rclk),
      .rst  (rst),
      .bus  (bus)
   );

   initial begin
      rclk = 1'b0;
      forever #5 rclk = ~rclk;
   end

   function automatic void add(input logic exu, input logic spu, input logic acc,
                               input logic shf, input logic r,
                               input logic eg, input logic sg, input logic shg);
      vec_t v;
      v.exu = exu; v.spu = spu; v.acc = acc; v.shf = shf; v.rst = r;
      v.eg = eg; v.sg = sg; v.shg = shg;
      vecs.push_back(v);
   endfunction

   function automatic void idle(input int n);
      for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   initial begin
      logic [6:0] exp_o, got_o;
      logic [3:0] exp_a, got_a;
      vec_t v;
      ev_t  e;

      n_vec = 0; n_cmp = 0; n_err = 0;
      rst = 1'b1;
      bus.exu_mul_req = 1'b0; bus.spu_mul_req = 1'b0;
      bus.spu_mul_acc = 1'b0; bus.spu_shf_req = 1'b0;

      // reset, with requests present that must not be granted
      add(0, 0, 0, 0, 1, 0, 0, 0);
      add(1, 1, 1, 1, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 0);
      idle(2);
      // single EXU op: grant now, ack LAT cycles later
      add(1, 0, 0, 0, 0, 1, 0, 0);
      idle(7);
      // starvation: E,E,E,S repeating
      add(1, 1, 1, 0, 0, 1, 0, 0);
      add(1, 1, 1, 0, 0, 1, 0, 0);
      add(1, 1, 1, 0, 0, 1, 0, 0);
      add(1, 1, 1, 0, 0, 0, 1, 0);
      add(1, 1, 1, 0, 0, 1, 0, 0);
      add(1, 1, 1, 0, 0, 1, 0, 0);
      add(1, 1, 1, 0, 0, 1, 0, 0);
      add(1, 1, 1, 0, 0, 0, 1, 0);
      idle(7);
      // bypass held off by an in-flight MAC
      add(0, 1, 1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 1, 0);
      idle(7);
      // shift held off by an in-flight MAC
      add(0, 1, 1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 0, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 1);
      idle(3);
      // shift loses to EXU, then SPU multiply goes before shift
      add(1, 0, 0, 1, 0, 1, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 1);
      add(0, 1, 0, 1, 0, 0, 1, 0);
      add(0, 0, 0, 1, 0, 0, 0, 1);
      idle(7);
      // back-to-back mixed E,S,E
      add(1, 0, 0, 0, 0, 1, 0, 0);
      add(0, 1, 0, 0, 0, 0, 1, 0);
      add(1, 0, 0, 0, 0, 1, 0, 0);
      idle(7);
      // reset mid-op after building up the starvation count
      add(1, 1, 1, 0, 0, 1, 0, 0);
      add(1, 1, 1, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0, 0);
      idle(1);
      add(0, 0, 0, 0, 1, 0, 0, 0);
      idle(6);
      add(1, 1, 1, 0, 0, 1, 0, 0);
      add(1, 1, 1, 0, 0, 1, 0, 0);
      add(1, 1, 1, 0, 0, 1, 0, 0);
      add(1, 1, 1, 0, 0, 0, 1, 0);
      idle(7);

      for (int t = 0; t < vecs.size(); t++) begin
         v = vecs[t];
         @(posedge rclk);
         #1;
         rst             = v.rst;
         bus.exu_mul_req = v.exu;
         bus.spu_mul_req = v.spu;
         bus.spu_mul_acc = v.acc;
         bus.spu_shf_req = v.shf;
         @(negedge rclk);
         n_vec++;

         exp_o = {v.eg, v.sg, v.shg, v.eg | v.sg, v.sg, v.sg & v.acc, v.shg};
         got_o = {bus.exu_gnt, bus.spu_gnt, bus.spu_shf_gnt, bus.issue_vld,
                  bus.issue_spick, bus.issue_acc, bus.issue_shf};
         n_cmp++;
         if (got_o !== exp_o) begin
            n_err++;
            $display("FAIL grant_issue vec %0d: got %b expected %b", t, got_o, exp_o);
         end

         exp_a = 4'b0000;
         if (v.rst) begin
            sb.delete();
         end else begin
            keep.delete();
            if (sb.size() > 0) exp_a[0] = 1'b1;
            foreach (sb[i]) begin
               if (sb[i].due == t) exp_a[3 - sb[i].kind] = 1'b1;
               else keep.push_back(sb[i]);
            end
            sb = keep;
         end
         got_a = {bus.mul_exu_ack, bus.mul_spu_ack, bus.mul_spu_shf_ack, bus.busy};
         n_cmp++;
         if (got_a !== exp_a) begin
            n_err++;
            $display("FAIL ack_busy vec %0d: got %b expected %b (exu,spu,shf,busy)", t, got_a, exp_a);
         end

         if (v.eg)  begin e.due = t + LAT; e.kind = 0; sb.push_back(e); end
         if (v.sg)  begin e.due = t + LAT; e.kind = 1; sb.push_back(e); end
         if (v.shg) begin e.due = t + 1;   e.kind = 2; sb.push_back(e); end
      end

      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d outstanding acks expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
